// File: rtl/ecl_access_ctrl.sv
// Access controller for the electronic combination lock: button edge detection,
// code entry, match/mismatch evaluation, timed unlock and failure lockout.
module ecl_access_ctrl #(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] CODE_RESET     = 5'b01011,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  UNLOCK_CYCLES  = 500,
  parameter int                  LOCKOUT_CYCLES = 1000,
  parameter int                  TIMEOUT_CYCLES = 200
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                but_0,
  input  logic                but_1,
  input  logic                prog_we,
  input  logic [CODE_LEN-1:0] prog_code,
  output logic                UNLOCK,
  output logic                LOCKED_OUT,
  output logic [3:0]          fail_cnt,
  output logic                entry_active
);

  localparam int MAX_UL  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int MAX_CYC = (MAX_UL > TIMEOUT_CYCLES) ? MAX_UL : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(CODE_LEN + 1);

  // The counter runs down to zero, so each load is one less than the duration.
  localparam logic [CNT_W-1:0] UNLOCK_LD  = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CODE_LEN - 1);
  localparam logic [3:0]       FAIL_MAX   = 4'(MAX_FAIL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_OPEN,
    ST_LOCKOUT
  } state_e;

  state_e              state_q, state_d;
  logic                but_0_q, but_1_q;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          fail_q, fail_d;
  logic                unlock_q, locked_q;

  logic                ev0, ev1, ev, digit;
  logic [CODE_LEN:0]   shift_ext;
  logic [CODE_LEN-1:0] entered;
  logic [3:0]          fail_inc;
  logic                do_eval;

  // A rise only counts while the other button is low, so chords and
  // press-while-holding never produce a digit.
  assign ev0   = but_0 & ~but_0_q & ~but_1;
  assign ev1   = but_1 & ~but_1_q & ~but_0;
  assign ev    = ev0 | ev1;
  assign digit = ev1;

  assign shift_ext = {shift_q, digit};
  assign entered   = shift_ext[CODE_LEN-1:0];
  assign fail_inc  = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 4'd1;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    code_d  = code_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    do_eval = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ev) begin
          shift_d = CODE_LEN'(digit);
          idx_d   = IDX_W'(1);
          if (CODE_LEN == 1) begin
            do_eval = 1'b1;
          end else begin
            state_d = ST_ENTRY;
            cnt_d   = TIMEOUT_LD;
          end
        end
      end

      ST_ENTRY: begin
        // An event on the expiry edge wins over the timeout.
        if (ev) begin
          shift_d = entered;
          idx_d   = idx_q + 1'b1;
          cnt_d   = TIMEOUT_LD;
          if (idx_q == IDX_LAST) begin
            do_eval = 1'b1;
          end
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end

      ST_OPEN: begin
        if (prog_we) begin
          code_d = prog_code;
        end
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end

      ST_LOCKOUT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (do_eval) begin
      idx_d = '0;
      if (entered == code_q) begin
        state_d = ST_OPEN;
        cnt_d   = UNLOCK_LD;
        fail_d  = '0;
      end else begin
        fail_d = fail_inc;
        if (fail_inc == FAIL_MAX) begin
          state_d = ST_LOCKOUT;
          cnt_d   = LOCKOUT_LD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      but_0_q  <= 1'b0;
      but_1_q  <= 1'b0;
      shift_q  <= '0;
      // NOTE: the combination register is reset like any other flop; it must
      // revert to the factory code, so it cannot be left to a RAM-style init.
      code_q   <= CODE_RESET;
      idx_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      unlock_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // which the edge detector relies on.
      state_q  <= state_d;
      but_0_q  <= but_0;
      but_1_q  <= but_1;
      shift_q  <= shift_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      unlock_q <= (state_d == ST_OPEN);
      locked_q <= (state_d == ST_LOCKOUT);
    end
  end

  assign UNLOCK       = unlock_q;
  assign LOCKED_OUT   = locked_q;
  assign fail_cnt     = fail_q;
  assign entry_active = (state_q == ST_ENTRY);

endmodule

// File: tb/tb_ecl_access_ctrl.sv
// Self-checking bench for ecl_access_ctrl: code attempts are scored against a
// small lock model; durations, timeouts, programming and async reset are checked.
module tb_ecl_access_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       but_0 = 1'b0;
  logic       but_1 = 1'b0;
  logic       prog_we = 1'b0;
  logic [4:0] prog_code = 5'b0;
  logic       UNLOCK, LOCKED_OUT, entry_active;
  logic [3:0] fail_cnt;

  always #5 CLK = ~CLK;

  ecl_access_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .but_0        (but_0),
    .but_1        (but_1),
    .prog_we      (prog_we),
    .prog_code    (prog_code),
    .UNLOCK       (UNLOCK),
    .LOCKED_OUT   (LOCKED_OUT),
    .fail_cnt     (fail_cnt),
    .entry_active (entry_active)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    string      tag;
    logic       unlock;
    logic       lockout;
    logic [3:0] fails;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] comb_m = 5'b01011;
  int         fail_m = 0;

  // One press: button high for one cycle; returns at the negedge after the event edge.
  task automatic press(input bit d);
    @(negedge CLK);
    if (d) but_1 = 1'b1;
    else   but_0 = 1'b1;
    @(negedge CLK);
    but_0 = 1'b0;
    but_1 = 1'b0;
  endtask

  task automatic attempt(input logic [4:0] code, input string tag);
    exp_t e;
    e.tag = tag;
    if (code == comb_m) begin
      fail_m    = 0;
      e.unlock  = 1'b1;
      e.lockout = 1'b0;
    end else begin
      fail_m++;
      e.unlock  = 1'b0;
      e.lockout = (fail_m == 3);
    end
    e.fails = 4'(fail_m);
    exp_q.push_back(e);
    for (int i = 4; i >= 0; i--) press(code[i]);
    e = exp_q.pop_front();
    check({e.tag, ".unlock"},  UNLOCK,     e.unlock);
    check({e.tag, ".lockout"}, LOCKED_OUT, e.lockout);
    check({e.tag, ".fails"},   fail_cnt,   e.fails);
  endtask

  // Counts negedges on which the selected output is high, bounded.
  task automatic count_high(input bit which, output int n);
    n = 0;
    while (((which ? LOCKED_OUT : UNLOCK) == 1'b1) && n < 3000) begin
      n++;
      @(negedge CLK);
    end
  endtask

  int n;

  initial begin
    #12;
    check("rst.unlock", UNLOCK, 0);
    check("rst.lockout", LOCKED_OUT, 0);
    check("rst.fails", fail_cnt, 0);
    check("rst.entry", entry_active, 0);
    check("rst.code", dut.code_q, 5'b01011);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // Correct code opens for exactly 500 cycles.
    attempt(5'b01011, "open1");
    count_high(1'b0, n);
    check("open1.len", n, 500);
    check("open1.state", dut.state_q, 0);

    // Three failures lead to lockout; presses during lockout do nothing.
    attempt(5'b11000, "bad1");
    attempt(5'b11000, "bad2");
    attempt(5'b11000, "bad3");
    for (int i = 4; i >= 0; i--) press(comb_m[i]);
    check("lock.press_unlock", UNLOCK, 0);
    check("lock.press_lockout", LOCKED_OUT, 1);
    check("lock.press_idx", dut.idx_q, 0);
    // 10 of the 1000 lockout cycles were spent on the ignored presses.
    count_high(1'b1, n);
    check("lock.len_rest", n, 990);
    fail_m = 0;
    check("lock.fails_after", fail_cnt, 0);

    // Timeout: a digit on the exact expiry edge is accepted, then idle expiry.
    press(1'b0);
    repeat (198) @(negedge CLK);
    press(1'b1);
    check("tmo.edge_idx", dut.idx_q, 2);
    check("tmo.edge_entry", entry_active, 1);
    repeat (199) @(negedge CLK);
    check("tmo.before", entry_active, 1);
    @(negedge CLK);
    check("tmo.after", entry_active, 0);
    check("tmo.state", dut.state_q, 0);
    check("tmo.idx", dut.idx_q, 0);
    check("tmo.fails", fail_cnt, 0);
    attempt(5'b01011, "tmo.open");
    count_high(1'b0, n);
    check("tmo.open_len", n, 500);

    // Chord and held buttons.
    @(negedge CLK);
    but_0 = 1'b1;
    but_1 = 1'b1;
    @(negedge CLK);
    check("chord.idx", dut.idx_q, 0);
    check("chord.entry", entry_active, 0);
    but_0 = 1'b0;
    but_1 = 1'b0;
    @(negedge CLK);
    but_0 = 1'b1;
    repeat (25) @(negedge CLK);
    but_1 = 1'b1;
    repeat (25) @(negedge CLK);
    check("hold.idx", dut.idx_q, 1);
    check("hold.entry", entry_active, 1);
    but_0 = 1'b0;
    but_1 = 1'b0;
    repeat (210) @(negedge CLK);
    check("hold.timeout", entry_active, 0);

    // Programming while open; write in idle is dropped.
    attempt(5'b01011, "prog.open");
    @(negedge CLK);
    prog_we   = 1'b1;
    prog_code = 5'b11100;
    @(negedge CLK);
    prog_we   = 1'b0;
    comb_m    = 5'b11100;
    check("prog.code", dut.code_q, 5'b11100);
    count_high(1'b0, n);
    check("prog.open_rest", n, 498);
    attempt(5'b11100, "prog.new_ok");
    count_high(1'b0, n);
    check("prog.new_len", n, 500);
    attempt(5'b01011, "prog.old_bad");
    @(negedge CLK);
    prog_we   = 1'b1;
    prog_code = 5'b01011;
    @(negedge CLK);
    prog_we   = 1'b0;
    check("prog.idle_drop", dut.code_q, 5'b11100);
    attempt(5'b11100, "prog.again");
    count_high(1'b0, n);
    check("prog.again_len", n, 500);

    // Asynchronous reset during OPEN.
    attempt(5'b11100, "rst_open");
    repeat (20) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("rst_open.unlock", UNLOCK, 0);
    check("rst_open.entry", entry_active, 0);
    check("rst_open.code", dut.code_q, 5'b01011);
    comb_m = 5'b01011;
    fail_m = 0;
    @(negedge CLK);
    RESET = 1'b1;

    // Asynchronous reset during LOCKOUT.
    attempt(5'b00000, "rl1");
    attempt(5'b00000, "rl2");
    attempt(5'b00000, "rl3");
    repeat (30) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("rst_lock.lockout", LOCKED_OUT, 0);
    check("rst_lock.fails", fail_cnt, 0);
    check("rst_lock.state", dut.state_q, 0);
    fail_m = 0;
    @(negedge CLK);
    RESET = 1'b1;
    attempt(5'b01011, "rst_lock.open");
    count_high(1'b0, n);
    check("rst_lock.open_len", n, 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ecl_access_ctrl.md
# ecl_access_ctrl

Access controller for the electronic combination lock. It turns the two raw button levels into single digit events and collects a fixed-length code. On a match it opens the lock for a bounded time; on a mismatch it counts the failure, and repeated failures trigger a timed lockout. It sits between the debounced front-panel buttons and the lock actuator driver, and holds the only writable copy of the combination.

## Interface
- CODE_LEN, 5: digits per code (1..16).
- CODE_RESET, 5'b01011: combination after reset. The first digit entered is the MSB.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (1..15).
- UNLOCK_CYCLES, 500: cycles UNLOCK is held high after a match.
- LOCKOUT_CYCLES, 1000: cycles of lockout.
- TIMEOUT_CYCLES, 200: maximum idle gap between digits during entry.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- but_0  in  1  button "0" level, synchronous to CLK.
- but_1  in  1  button "1" level, synchronous to CLK.
- prog_we  in  1  one-cycle code write strobe.
- prog_code  in  CODE_LEN  new combination.
- UNLOCK  out  1  actuator enable, registered.
- LOCKED_OUT  out  1  lockout indicator, registered.
- fail_cnt  out  4  consecutive failure count.
- entry_active  out  1  high while a code is being entered.

## Operation
- Digit events:
  - but_0 and but_1 are registered each cycle.
  - ev0 = but_0 & ~but_0_q & ~but_1.
  - ev1 = but_1 & ~but_1_q & ~but_0.
  - If both rise in the same cycle, or one rises while the other is held, no event is generated.
  - A held button produces exactly one event.
- States:
  - IDLE:
    - Any event shifts the digit into the entry shift register and sets idx=1.
    - If CODE_LEN==1, the code is evaluated immediately.
    - Otherwise → ENTRY.
  - ENTRY:
    - Each event shifts in a digit and increments idx.
    - An event with idx==CODE_LEN-1 evaluates the full code, including the new digit.
    - The code is never rejected early; all CODE_LEN digits are always collected.
    - The inter-digit timer resets on each event. At TIMEOUT_CYCLES with no event → IDLE, idx=0, fail_cnt unchanged.
  - Evaluation:
    - Match → OPEN, fail_cnt=0.
    - Mismatch → fail_cnt+1. If the new value equals MAX_FAIL → LOCKOUT, else → IDLE.
  - OPEN:
    - UNLOCK=1 for UNLOCK_CYCLES, then → IDLE.
    - Digit events are ignored.
    - prog_we loads prog_code into the combination register. A write is accepted only in this state; writes in any other state are dropped.
  - LOCKOUT:
    - LOCKED_OUT=1 for LOCKOUT_CYCLES; digit events and prog_we are ignored.
    - On expiry: fail_cnt=0 → IDLE.
- entry_active = (state==ENTRY).
- Counters:
  - One shared down-counter, width $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES)+1).
  - It is loaded on every state entry and on each ENTRY event. It never wraps.
  - fail_cnt saturates at MAX_FAIL.
- Reset: state IDLE, combination=CODE_RESET, idx=0, UNLOCK=0, LOCKED_OUT=0, fail_cnt=0, entry_active=0, button registers 0.

## Timing
- The final digit sampled at edge k:
  - Match: UNLOCK is high from edge k to edge k+UNLOCK_CYCLES, exactly UNLOCK_CYCLES cycles.
  - Lockout: LOCKED_OUT is high for exactly LOCKOUT_CYCLES cycles starting at edge k.
- Timeout:
  - The last event is at edge k.
  - At edge k+TIMEOUT_CYCLES the block returns to IDLE.
  - An event sampled at exactly edge k+TIMEOUT_CYCLES is accepted and takes precedence over the timeout.
- Entering a new code:
  - prog_we at edge k updates the combination at edge k.
  - An entry started in the following IDLE period compares against the new value.
  - prog_we does not change the open time: UNLOCK still ends at the scheduled edge.
- An event on the same edge the block returns to IDLE from OPEN or LOCKOUT is ignored. The first accepted digit is at the next edge or later.
- Asserting RESET mid-operation clears all outputs immediately and asynchronously. The combination reverts to CODE_RESET.

## Test plan
- Reset, then press 0,1,0,1,1 as separate presses → UNLOCK high for exactly 500 cycles, fail_cnt=0.
- Enter 1,1,0,0,0 three times → fail_cnt goes 1 then 2; on the third attempt LOCKED_OUT is high for 1000 cycles and presses made during it have no effect; afterwards fail_cnt=0.
- Press 0,1, then wait 200 idle cycles → entry_active drops and state is IDLE; a full correct entry afterwards unlocks.
- Raise both buttons in the same cycle, and hold but_0 for 50 cycles → no event, then exactly one event, each checked by idx.
- While OPEN, prog_we with prog_code=5'b11100 → 11100 then unlocks and 01011 fails; the same write issued in IDLE is dropped.
- Assert RESET during LOCKOUT and during OPEN → all outputs return to 0 immediately and the combination is back to 01011.
